// File: rtl/mem_region_switch_if.sv
// mem_region_switch_if: CPU data-port bus between the CPU and the memory-map switch.
//
// Signals:
//   m_addr   CPU address                        (CPU -> switch)
//   m_wdata  CPU write data                     (CPU -> switch)
//   m_read   single-cycle read strobe           (CPU -> switch)
//   m_write  single-cycle write strobe          (CPU -> switch)
//   m_rdata  read data, valid while m_ready = 1 (switch -> CPU)
//   m_busy   transaction in progress            (switch -> CPU)
//   m_ready  one-cycle completion pulse         (switch -> CPU)
//   m_err    one-cycle error pulse with m_ready (switch -> CPU)
//
// Modports: master = CPU side, slave = switch side.
interface mem_region_switch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_rdata;
    logic              m_busy;
    logic              m_ready;
    logic              m_err;

    modport master (
        output m_addr, m_wdata, m_read, m_write,
        input  m_rdata, m_busy, m_ready, m_err
    );

    modport slave (
        input  m_addr, m_wdata, m_read, m_write,
        output m_rdata, m_busy, m_ready, m_err
    );
endinterface

// File: rtl/mem_region_switch.sv
// mem_region_switch: memory-map switch between the CPU data port and N_REG
// memory-mapped slaves. The CPU address is decoded into a region, rebased to a
// slave-local address, and a registered request/response FSM runs against the
// selected slave. Adds write-only regions, a wait timeout with bus error and an
// unmapped-address fast path.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   cpu      CPU bus (mem_region_switch_if, slave modport)
//   s_addr   rebased address (latched addr - base of selected region)
//   s_wdata  latched write data
//   s_read   per-region read request
//   s_write  per-region write request
//   s_busy   per-region "accepted / working"
//   s_ready  per-region "done, read data valid"
//   s_rdata  per-region read data, region i in slice i
module mem_region_switch #(
    parameter int                        ADDR_W   = 16,
    parameter int                        DATA_W   = 16,
    parameter int                        N_REG    = 3,
    parameter logic [N_REG*ADDR_W-1:0]   REG_BASE = {16'h4c00, 16'h1000, 16'h0000},
    parameter logic [N_REG-1:0]          WR_ONLY  = 3'b010,
    parameter int                        TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mem_region_switch_if.slave         cpu,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [N_REG-1:0]           s_read,
    output logic [N_REG-1:0]           s_write,
    input  logic [N_REG-1:0]           s_busy,
    input  logic [N_REG-1:0]           s_ready,
    input  logic [N_REG*DATA_W-1:0]    s_rdata
);

    localparam int         SEL_W = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam logic [7:0] TMO   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel_q;
    logic               wr_q;
    logic [7:0]         cnt_q, cnt_nxt;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    // Address decode: bases ascend, so the last matching base is the region.
    logic [SEL_W-1:0]   dec_sel;
    logic [ADDR_W-1:0]  dec_base;
    logic               dec_hit;

    always_comb begin
        dec_sel  = '0;
        dec_base = '0;
        dec_hit  = 1'b0;
        for (int i = 0; i < N_REG; i++) begin
            if (cpu.m_addr >= REG_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_sel  = SEL_W'(i);
                dec_base = REG_BASE[i*ADDR_W +: ADDR_W];
                dec_hit  = 1'b1;
            end
        end
    end

    // Only the selected slave's handshake and data are looked at.
    logic               sel_busy;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic               timed_out;

    assign sel_busy  = s_busy[sel_q];
    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_rdata[sel_q*DATA_W +: DATA_W];
    assign timed_out = (cnt_q == TMO);

    logic               accept;
    logic               rdata_load;
    logic [DATA_W-1:0]  rdata_val;
    logic               done_err;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_q;
        accept     = 1'b0;
        rdata_load = 1'b0;
        rdata_val  = '0;
        done_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu.m_read || cpu.m_write) begin
                    accept = 1'b1;
                    // Fast path: conflicting strobes, unmapped address, or a
                    // read of a write-only region never reaches a slave.
                    if ((cpu.m_read && cpu.m_write) || !dec_hit ||
                        (cpu.m_read && WR_ONLY[dec_sel])) begin
                        state_nxt  = DONE;
                        rdata_load = 1'b1;
                        rdata_val  = '0;
                        done_err   = cpu.m_read && cpu.m_write;
                    end else begin
                        state_nxt = ISSUE;
                        cnt_nxt   = '0;
                    end
                end
            end
            ISSUE, WAIT: begin
                // s_ready takes priority over a timeout in the same cycle.
                if (sel_ready) begin
                    state_nxt  = DONE;
                    rdata_load = !wr_q;
                    rdata_val  = sel_rdata;
                end else if (timed_out) begin
                    state_nxt  = DONE;
                    rdata_load = 1'b1;
                    rdata_val  = '1;
                    done_err   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 8'd1;
                    if (state == ISSUE && sel_busy) begin
                        state_nxt = WAIT;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            if (accept) begin
                sel_q   <= dec_sel;
                wr_q    <= cpu.m_write;
                s_addr  <= cpu.m_addr - dec_base;
                s_wdata <= cpu.m_wdata;
            end
            if (rdata_load) begin
                rdata_q <= rdata_val;
            end
            if (state_nxt == DONE) begin
                err_q <= done_err;
            end
        end
    end

    // Strobes and status are decoded from registered state only, so an
    // asynchronous reset clears them immediately.
    logic [N_REG-1:0] sel_onehot;
    assign sel_onehot = N_REG'(1) << sel_q;

    assign s_read  = (state == ISSUE && !wr_q) ? sel_onehot : '0;
    assign s_write = (state == ISSUE &&  wr_q) ? sel_onehot : '0;

    assign cpu.m_rdata = rdata_q;
    assign cpu.m_busy  = (state == ISSUE) || (state == WAIT);
    assign cpu.m_ready = (state == DONE);
    assign cpu.m_err   = (state == DONE) && err_q;

endmodule

// File: tb/tb_mem_region_switch.sv
// tb_mem_region_switch: directed bench for mem_region_switch with default
// parameters (regions at 0x0000, 0x1000, 0x4c00; region 1 write-only; TIMEOUT 255).
// Cycle n means n rising edges after the edge that sampled the CPU strobe.
module tb_mem_region_switch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_addr;
    logic [15:0] s_wdata;
    logic [2:0]  s_read;
    logic [2:0]  s_write;
    logic [2:0]  s_busy = '0;
    logic [2:0]  s_ready = '0;
    logic [47:0] s_rdata = '0;

    int errors = 0;
    int checks = 0;

    mem_region_switch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_region_switch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu     (bus),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_read  (s_read),
        .s_write (s_write),
        .s_busy  (s_busy),
        .s_ready (s_ready),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        s_busy      = '0;
        s_ready     = '0;
        s_rdata     = '0;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.m_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.m_busy); end
        checks++; if (bus.m_ready !== 1'b0 || bus.m_err !== 1'b0) begin errors++; $display("FAIL rst_ready_err: got %b%b want 00", bus.m_ready, bus.m_err); end
        checks++; if (bus.m_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h want 0000", bus.m_rdata); end
        checks++; if (s_read !== 3'b000 || s_write !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b/%b want 000/000", s_read, s_write); end
        checks++; if (s_addr !== 16'h0000 || s_wdata !== 16'h0000) begin errors++; $display("FAIL rst_s_bus: got %h/%h want 0000/0000", s_addr, s_wdata); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_zero_wait();
        bus.m_addr = 16'h1005; bus.m_wdata = 16'h1234; bus.m_write = 1'b1;
        step();  // cycle 1: ISSUE
        quiet();
        checks++; if (s_write !== 3'b010 || s_read !== 3'b000) begin errors++; $display("FAIL wr_strobe: got w=%b r=%b want w=010 r=000", s_write, s_read); end
        checks++; if (s_addr !== 16'h0005) begin errors++; $display("FAIL wr_s_addr: got %h want 0005", s_addr); end
        checks++; if (s_wdata !== 16'h1234) begin errors++; $display("FAIL wr_s_wdata: got %h want 1234", s_wdata); end
        checks++; if (bus.m_busy !== 1'b1 || bus.m_ready !== 1'b0) begin errors++; $display("FAIL wr_busy_c1: got busy=%b ready=%b want 1 0", bus.m_busy, bus.m_ready); end
        s_ready = 3'b010;
        step();  // cycle 2: DONE
        s_ready = 3'b000;
        checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0) begin errors++; $display("FAIL wr_done: got ready=%b err=%b want 1 0", bus.m_ready, bus.m_err); end
        checks++; if (s_write !== 3'b000 || bus.m_busy !== 1'b0) begin errors++; $display("FAIL wr_drop: got s_write=%b busy=%b want 000 0", s_write, bus.m_busy); end
        step();  // cycle 3: IDLE
        checks++; if (bus.m_ready !== 1'b0) begin errors++; $display("FAIL wr_pulse: got ready=%b want 0", bus.m_ready); end
    endtask

    task automatic test_read_wait();
        int early = 0;
        bus.m_addr = 16'h4c10; bus.m_read = 1'b1;
        step();  // cycle 1: ISSUE
        quiet();
        checks++; if (s_read !== 3'b100 || s_write !== 3'b000) begin errors++; $display("FAIL rd_strobe: got r=%b w=%b want r=100 w=000", s_read, s_write); end
        checks++; if (s_addr !== 16'h0010) begin errors++; $display("FAIL rd_s_addr: got %h want 0010", s_addr); end
        s_busy = 3'b100;
        for (int c = 2; c <= 6; c++) begin
            step();
            if (bus.m_ready !== 1'b0 || bus.m_busy !== 1'b1 || s_read !== 3'b000) early++;
            // unselected regions signal ready in cycle 3; must be ignored
            s_ready = (c == 3) ? 3'b011 : (c == 6) ? 3'b100 : 3'b000;
            s_rdata = (c == 6) ? {16'hBEEF, 16'h1111, 16'h2222} : {16'h0000, 16'h3333, 16'h4444};
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL rd_wait_phase: got %0d bad cycles want 0", early); end
        step();  // cycle 7: DONE
        s_ready = '0; s_busy = '0; s_rdata = '0;
        checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0) begin errors++; $display("FAIL rd_done: got ready=%b err=%b want 1 0", bus.m_ready, bus.m_err); end
        checks++; if (bus.m_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata: got %h want beef", bus.m_rdata); end
        step();  // cycle 8: IDLE, data held
        checks++; if (bus.m_ready !== 1'b0 || bus.m_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_hold: got ready=%b rdata=%h want 0 beef", bus.m_ready, bus.m_rdata); end
    endtask

    task automatic test_wr_only_read();
        bus.m_addr = 16'h1000; bus.m_read = 1'b1;
        step();  // cycle 1: DONE
        quiet();
        checks++; if (s_read !== 3'b000) begin errors++; $display("FAIL wo_s_read: got %b want 000", s_read); end
        checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0 || bus.m_busy !== 1'b0) begin errors++; $display("FAIL wo_done: got ready=%b err=%b busy=%b want 1 0 0", bus.m_ready, bus.m_err, bus.m_busy); end
        checks++; if (bus.m_rdata !== 16'h0000) begin errors++; $display("FAIL wo_rdata: got %h want 0000", bus.m_rdata); end
        step();
    endtask

    task automatic test_both_strobes();
        bus.m_addr = 16'h4c00; bus.m_read = 1'b1; bus.m_write = 1'b1;
        step();  // cycle 1: DONE with error
        quiet();
        checks++; if (s_read !== 3'b000 || s_write !== 3'b000) begin errors++; $display("FAIL both_strobes: got r=%b w=%b want 000 000", s_read, s_write); end
        checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b1) begin errors++; $display("FAIL both_err: got ready=%b err=%b want 1 1", bus.m_ready, bus.m_err); end
        step();
        checks++; if (bus.m_ready !== 1'b0 || bus.m_err !== 1'b0) begin errors++; $display("FAIL both_pulse: got ready=%b err=%b want 0 0", bus.m_ready, bus.m_err); end
    endtask

    task automatic test_timeout(input logic race);
        int early = 0;
        bus.m_addr = 16'h4c00; bus.m_read = 1'b1;
        step();  // cycle 1: ISSUE entry
        quiet();
        for (int c = 1; c <= 256; c++) begin
            if (bus.m_ready !== 1'b0 || s_read !== 3'b100) early++;
            if (c < 256) step();
        end
        if (race) begin
            s_ready = 3'b100;
            s_rdata = {16'h5A5A, 16'h0000, 16'h0000};
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_hold%0d: got %0d bad cycles want 0", race, early); end
        step();  // cycle 257
        s_ready = '0; s_rdata = '0;
        checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== !race) begin errors++; $display("FAIL to_done%0d: got ready=%b err=%b want 1 %b", race, bus.m_ready, bus.m_err, !race); end
        checks++; if (bus.m_rdata !== (race ? 16'h5A5A : 16'hFFFF)) begin errors++; $display("FAIL to_rdata%0d: got %h want %h", race, bus.m_rdata, race ? 16'h5A5A : 16'hFFFF); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.m_addr = 16'h1010; bus.m_wdata = 16'h00AA; bus.m_write = 1'b1;
        step();  // cycle 1: ISSUE
        quiet();
        s_ready = 3'b010;
        step();  // cycle 2: DONE, strobe here must be ignored
        s_ready = '0;
        bus.m_addr = 16'h1000; bus.m_read = 1'b1;
        step();  // cycle 3: IDLE
        quiet();
        checks++; if (bus.m_ready !== 1'b0 || bus.m_busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored: got ready=%b busy=%b want 0 0", bus.m_ready, bus.m_busy); end
        bus.m_addr = 16'h0004; bus.m_read = 1'b1;
        step();  // cycle 4: ISSUE
        quiet();
        checks++; if (s_read !== 3'b001 || s_addr !== 16'h0004) begin errors++; $display("FAIL b2b_issue: got r=%b addr=%h want 001 0004", s_read, s_addr); end
        s_ready = 3'b001; s_rdata = {16'h0000, 16'h0000, 16'h0ABC};
        step();  // cycle 5: DONE
        quiet();
        checks++; if (bus.m_ready !== 1'b1 || bus.m_rdata !== 16'h0ABC) begin errors++; $display("FAIL b2b_done: got ready=%b rdata=%h want 1 0abc", bus.m_ready, bus.m_rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.m_addr = 16'h4c10; bus.m_read = 1'b1;
        step();  // cycle 1: ISSUE
        quiet();
        s_busy = 3'b100;
        step();  // cycle 2: WAIT
        step();  // cycle 3: WAIT
        checks++; if (bus.m_busy !== 1'b1) begin errors++; $display("FAIL rm_waiting: got busy=%b want 1", bus.m_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.m_busy !== 1'b0 || bus.m_ready !== 1'b0 || bus.m_err !== 1'b0) begin errors++; $display("FAIL rm_status: got busy=%b ready=%b err=%b want 0 0 0", bus.m_busy, bus.m_ready, bus.m_err); end
        checks++; if (bus.m_rdata !== 16'h0000 || s_addr !== 16'h0000 || s_read !== 3'b000) begin errors++; $display("FAIL rm_data: got rdata=%h addr=%h r=%b want 0000 0000 000", bus.m_rdata, s_addr, s_read); end
        s_busy = '0;
        step();
        rst_n = 1'b1;
        step();
        bus.m_addr = 16'h1005; bus.m_wdata = 16'h7777; bus.m_write = 1'b1;
        step();  // cycle 1
        quiet();
        checks++; if (s_write !== 3'b010 || s_wdata !== 16'h7777) begin errors++; $display("FAIL rm_after_issue: got w=%b wdata=%h want 010 7777", s_write, s_wdata); end
        s_ready = 3'b010;
        step();  // cycle 2
        s_ready = '0;
        checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0) begin errors++; $display("FAIL rm_after_done: got ready=%b err=%b want 1 0", bus.m_ready, bus.m_err); end
        step();
    endtask

    initial begin
        quiet();
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_wr_only_read();
        test_both_strobes();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_region_switch.md
Name: mem_region_switch

Overview:
- Parametrised memory-map switch between the CPU data port and N memory-mapped slaves (VRAM, SDRAM, ROM window, peripherals).
- Decodes the CPU address into a region, rebases it to a slave-local address, and runs a registered request/response FSM against the selected slave.
- Adds per-region write-only masking, a wait timeout with bus error, and an unmapped-region fast path, replacing the fixed combinational three-way split.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- N_REG, 3, number of slave regions (1..8).
- REG_BASE, {16'h4c00,16'h1000,16'h0000} packed N_REG*ADDR_W, base of region i in slice i.
  - Bases are strictly ascending.
  - Region i spans [BASE_i, BASE_{i+1}); the last region spans up to the top of the address space.
- WR_ONLY, 3'b010, bit i set: reads of region i return 0 without touching the slave.
- TIMEOUT, 255, maximum cycles spent in ISSUE+WAIT before a bus error; 8-bit counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- m_addr  input  ADDR_W  CPU address.
- m_wdata  input  DATA_W  CPU write data.
- m_read  input  1  read strobe, single cycle.
- m_write  input  1  write strobe, single cycle.
- m_rdata  output  DATA_W  read data, valid while m_ready=1.
- m_busy  output  1  transaction in progress.
- m_ready  output  1  one-cycle completion pulse.
- m_err  output  1  one-cycle error pulse, coincident with m_ready.
- s_addr  output  ADDR_W  rebased address: latched addr - BASE_sel.
- s_wdata  output  DATA_W  latched write data.
- s_read  output  N_REG  per-region read request.
- s_write  output  N_REG  per-region write request.
- s_busy  input  N_REG  slave accepted / working.
- s_ready  input  N_REG  slave done; read data valid.
- s_rdata  input  N_REG*DATA_W  per-region read data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n). Everything is clocked on posedge clk.
- Reset state:
  - State = IDLE.
  - m_busy = 0, m_ready = 0, m_err = 0.
  - m_rdata = 0, s_read = 0, s_write = 0.
  - s_addr = 0, s_wdata = 0, timeout counter = 0.
- Reset mid-transaction aborts it immediately. The slave sees its strobe drop and no completion is reported.
- Decode:
  - sel = highest i with m_addr >= BASE_i.
  - m_addr < BASE_0 is unmapped.
  - Rebase subtraction is ADDR_W-bit, so it cannot underflow for a mapped address.
- Strobes are sampled only in IDLE and ignored in every other state. The master waits for m_ready before issuing again.
- IDLE, on a strobe: latch addr/data/sel/op and raise m_busy.
  - Go to DONE, with m_rdata = 0 and no error, if any of these hold:
    - m_read and m_write both set: m_err = 1.
    - Unmapped address: reads return 0, writes are dropped.
    - Read to a WR_ONLY region.
  - Otherwise go to ISSUE.
- ISSUE: drive s_read[sel] or s_write[sel] = 1; the other strobes stay 0.
  - s_ready[sel] = 1: capture s_rdata[sel] if reading, drop the strobe, go to DONE.
  - Else s_busy[sel] = 1: drop the strobe, go to WAIT.
  - Else stay in ISSUE.
- WAIT: strobes are 0.
  - s_ready[sel] = 1: capture read data, go to DONE.
- Timeout:
  - The counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT, drop the strobes, set m_rdata = all-ones and m_err = 1, and go to DONE.
  - If s_ready arrives in the same cycle as the timeout, s_ready wins with no error.
- DONE: m_ready = 1 for exactly one cycle, m_busy = 0, then IDLE. A new strobe is accepted in the following IDLE cycle.
- m_rdata holds its value until the next completion.
- Latency, counting from the strobe cycle to the m_ready cycle:
  - 1 cycle for the unmapped / WR_ONLY-read / error paths.
  - 2 cycles for a slave that already has s_ready high in ISSUE.
  - 2+k cycles when s_ready arrives k cycles into WAIT.
- s_busy/s_ready from unselected regions are ignored.

Test Plan:
- Write 16'h1234 to 16'h1005 (region 1, zero-wait slave) -> s_write = 3'b010 for 1 cycle, s_addr = 16'h0005, s_wdata = 16'h1234; m_ready 2 cycles after the strobe, m_err = 0.
- Read 16'h4c10 with the SDRAM model busy for 5 cycles then ready with data 16'hBEEF -> s_addr = 16'h0010, m_rdata = 16'hBEEF, m_ready at cycle 7 relative to the strobe.
- Read 16'h1000 (WR_ONLY region 1) -> s_read stays 0, m_rdata = 0, m_ready 1 cycle later.
- m_read and m_write asserted together -> no slave strobe, m_err = m_ready = 1 for 1 cycle.
- Read to region 2 with a slave that never responds, TIMEOUT = 255 -> m_err = 1 and m_rdata = 16'hFFFF at cycle 256 after ISSUE entry; s_ready arriving in exactly that cycle yields m_err = 0 and the slave's data.
- Deassert rst_n during WAIT -> all outputs return to 0 asynchronously, state is IDLE, and the next strobe after release completes normally.
